mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port between the instruction fetch path (read-only) and the data path (read/write).
//  Sits between the request unit / datapath and the RAM model.
//  Data requests win by default. A starvation counter forces an instruction grant after STARVE_MAX
//  consecutive data grants made while a fetch was waiting.
//  A timeout releases a requester if the RAM never answers.
// PARAMETERS
//  ADDR_W      32   address width, both requesters and RAM
//  DATA_W      32   data width
//  STARVE_MAX  4    consecutive data grants (with iREN pending) before a forced fetch grant; >=1
//  TIMEOUT     255  cycles in an access state without ramready before abort; >=1
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       reset, asynchronous, active-low
//  iREN      in   1       fetch read request, held until iwait low
//  iaddr     in   ADDR_W  fetch address, stable while iREN high
//  iload     out  DATA_W  fetch read data, valid when iREN & !iwait
//  iwait     out  1       fetch stall
//  dREN      in   1       data read request
//  dWEN      in   1       data write request (wins if dREN also high)
//  daddr     in   ADDR_W  data address, stable while request high
//  dstore    in   DATA_W  write data
//  dload     out  DATA_W  data read data, valid when dREN & !dwait
//  dwait     out  1       data stall
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramready  in   1       RAM completes the strobed access this cycle
//  err       out  1       one-cycle pulse, the cycle after a timeout abort
// BEHAVIOUR
//  States: IDLE, D_ACC, I_ACC (registered). Reset: state=IDLE, starve_cnt=0, tmo_cnt=0, err=0.
//  IDLE:
//   - D_ACC if (dREN|dWEN) and not (iREN & starve_cnt==STARVE_MAX).
//   - Else I_ACC if iREN. Else stay in IDLE.
//   - RAM strobes low.
//  On entering D_ACC: starve_cnt++ (saturating) if iREN is high; else starve_cnt=0.
//  On entering I_ACC: starve_cnt=0.
//  Access states drive the RAM combinationally from the granted requester:
//   - D_ACC: ramWEN=dWEN; ramREN=dREN&!dWEN; ramaddr=daddr; ramstore=dstore.
//   - I_ACC: ramREN=iREN; ramWEN=0; ramaddr=iaddr.
//   - ramstore=0 whenever the access is not a data write.
//  Completion: ramready=1 in an access state drops the granted wait in that same cycle.
//   - Next state is always IDLE, giving one mandatory gap cycle.
//   - The gap keeps a stale, not-yet-dropped request from being re-granted.
//  Waits (combinational):
//   - iwait = iREN & !(I_ACC & (ramready|tmo_hit)).
//   - dwait = (dREN|dWEN) & !(D_ACC & (ramready|tmo_hit)).
//   - Under reset: iwait=iREN, dwait=dREN|dWEN.
//  iload=ramload and dload=ramload (pass-through). Meaningful only when the matching wait is low.
//  Latency: request seen in IDLE cycle N -> strobe in N+1 -> earliest completion N+1 (ramready same cycle).
//  Timeout counter:
//   - tmo_cnt clears on every state entry and increments each access cycle without ramready.
//   - tmo_hit = tmo_cnt==TIMEOUT-1 & !ramready.
//   - On tmo_hit: wait released, load data undefined, go to IDLE, err=1 the next cycle.
//  Abort: if the granted requester drops its request mid-access:
//   - RAM strobes drop immediately; state goes to IDLE next cycle.
//   - No err; starve_cnt unchanged.
//  ramready while in IDLE is ignored.
//  Async reset mid-access: strobes low at once; all state returns to reset values.
// TESTING
//  1. dREN only, daddr=0x40, ramload=0xCAFEF00D with ramready after 2 cycles
//     -> ramREN high 2 cycles, dload=0xCAFEF00D, dwait low on the ramready cycle, then 1 IDLE cycle.
//  2. iREN and dWEN in the same cycle, ramready=1 every access cycle
//     -> data write is served first (ramWEN=1, ramaddr=daddr), then the fetch after the gap cycle.
//  3. iREN held high with dREN held high, ramready=1 each access cycle
//     -> grant order D,D,D,D,I,D,... (STARVE_MAX=4).
//  4. dWEN held with ramready never asserted, TIMEOUT=8
//     -> 8 cycles of ramWEN, dwait drops on the 8th, err pulses exactly once on the next cycle.
//  5. iREN dropped on the 2nd cycle of I_ACC
//     -> ramREN drops in that same cycle, state is IDLE the next cycle, err stays 0.
//  6. nRST asserted during D_ACC write -> ramWEN low immediately, and the next grant after release starts from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between fetch (read-only) and data (read/write) requesters
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   starve_cnt, starve_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic            err_nx;
    logic            dreq, starved, tmo_hit, granted_req, finish;

    assign dreq    = dREN | dWEN;
    assign starved = iREN && (starve_cnt == SW'(STARVE_MAX));
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1)) && !ramready;
    assign finish  = ramready | tmo_hit;
    assign iload   = ramload;
    assign dload   = ramload;

    always_comb begin
        state_nx    = state;
        starve_nx   = starve_cnt;
        tmo_nx      = '0;
        err_nx      = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = iREN;
        dwait       = dreq;
        granted_req = 1'b0;

        case (state)
            IDLE: begin
                if (dreq && !starved) begin
                    state_nx = D_ACC;
                    if (!iREN)
                        starve_nx = '0;
                    else if (starve_cnt != SW'(STARVE_MAX))
                        starve_nx = starve_cnt + 1'b1;
                end else if (iREN) begin
                    state_nx  = I_ACC;
                    starve_nx = '0;
                end
            end
            D_ACC: begin
                granted_req = dreq;
                ramWEN      = dWEN;
                ramREN      = dREN & !dWEN;
                ramaddr     = daddr;
                ramstore    = dWEN ? dstore : '0;
                dwait       = dreq & !finish;
            end
            I_ACC: begin
                granted_req = iREN;
                ramREN      = iREN;
                ramaddr     = iaddr;
                iwait       = iREN & !finish;
            end
            default: state_nx = IDLE;
        endcase

        // A dropped request aborts silently; completion or timeout always passes through IDLE.
        if (state != IDLE) begin
            if (!granted_req) begin
                state_nx = IDLE;
            end else if (finish) begin
                state_nx = IDLE;
                err_nx   = tmo_hit;
            end else begin
                tmo_nx = tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            tmo_cnt    <= tmo_nx;
            err        <= err_nx;
        end
    end
endmodule
